uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- Receive stage directly downstream of the baud prescaler in the UART_BCD datapath.
- Consumes the prescaler's oversample tick (OS_RATE ticks per bit) and the raw RX pin.
- Deserialises 8N1 frames, LSB first, into parallel bytes for the BCD display logic.
- Flags framing errors and drops start-bit glitches.

Parameters:
- DATA_BITS, 8, data bits per frame.
- OS_RATE, 16, oversample ticks per bit period; must be even and at least 4.

Ports:
- src_clk  input  1  system clock (50 MHz on board).
- rst  input  1  synchronous active-high reset.
- enable  input  1  receiver enable (SW[0]); low forces idle.
- os_tick  input  1  one-cycle oversample strobe from the prescaler.
- rx_in  input  1  raw asynchronous RX line; idle high.
- rx_data  output  DATA_BITS  last good received byte.
- rx_valid  output  1  one-cycle strobe: rx_data was updated this cycle.
- frame_err  output  1  one-cycle strobe: stop bit sampled low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Clocking and reset: one clock, src_clk. rst is synchronous and active-high; it is sampled only on the src_clk rising edge.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, busy=0, state=IDLE, counters=0, both synchroniser flops=1.
- rx_in passes through a 2-flop synchroniser to give rx_s. Only rx_s is used internally.
- tick_cnt is $clog2(OS_RATE) bits wide. bit_cnt is $clog2(DATA_BITS) bits wide. The shift register is DATA_BITS wide.
- State and counters change only in cycles where os_tick=1. The exceptions are rst and enable=0.
- IDLE: when os_tick=1 and rx_s=0, go to START with tick_cnt=0.
- START: tick_cnt increments each os_tick. When tick_cnt=OS_RATE/2-1 (start-bit midpoint):
  - rx_s=0: go to DATA with tick_cnt=0 and bit_cnt=0.
  - rx_s=1: glitch; return to IDLE with no strobe.
- DATA: when tick_cnt=OS_RATE-1, sample rx_s into the shift register MSB and shift right (LSB-first reception), then clear tick_cnt.
  - When bit_cnt=DATA_BITS-1 on that sample, go to STOP. Otherwise increment bit_cnt.
- STOP: when tick_cnt=OS_RATE-1 (stop-bit midpoint):
  - rx_s=1: load rx_data from the shift register and pulse rx_valid.
  - rx_s=0: pulse frame_err; rx_data is unchanged.
  - Either way, go to IDLE. Returning at mid stop bit lets a back-to-back start bit be detected.
- Latency: the rx_valid or frame_err strobe is high for exactly one src_clk cycle. It asserts on the cycle after the os_tick edge that samples the stop midpoint.
- enable=0: synchronously forces IDLE and clears the counters and shift register. No strobes are produced and rx_data holds its value. Re-enabling starts in IDLE.
- rx_valid and frame_err are never high in the same cycle.
- os_tick held high continuously is legal; the block then advances once per clock.
- Reset mid-frame: the frame is abandoned and no strobe is produced.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one even-parity bit at its midpoint.
  - A mismatch sets a latched parity-fault flag. The frame then continues through STOP, but rx_valid is suppressed and rx_data is not updated.
  - An extra output port parity_err (1 bit) pulses for one cycle at the STOP decision when the fault flag is set. It is exclusive with rx_valid.
  - frame_err still has priority: if the stop bit is also low, frame_err pulses and parity_err does not.
- Undefined: no PARITY state and no parity_err port; 8N1 only.

Test Plan:
- Setup for all scenarios: os_tick every 4 src_clk cycles; OS_RATE=16 (64 clocks per bit); enable=1 unless stated.
- Frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) -> exactly one rx_valid pulse, rx_data=0xA5, frame_err never high, busy low after the stop midpoint.
- Frame 0x3C with stop bit driven 0 -> one frame_err pulse, no rx_valid, rx_data keeps its previous value 0xA5.
- rx_in low for 3 os_ticks then high -> START aborts, no strobes, busy returns low within OS_RATE/2 ticks.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_valid pulses, with rx_data=0x00 then 0xFF.
- enable dropped after 4 data bits, restored, then frame 0x81 sent -> no strobe for the aborted frame, then rx_valid with rx_data=0x81.
- UART_PARITY_EN defined, frame 0x07 with parity bit=0 (wrong; correct is 1) -> parity_err pulse, no rx_valid, rx_data unchanged.

Source files
------------

// File: rtl/uart_rx_os_if.sv
// rtl/uart_rx_os_if.sv - Signal bundle between the oversampling UART receiver and its environment.
// UART_PARITY_EN adds the parity_err strobe.
interface uart_rx_os_if #(parameter int DATA_BITS = 8);
  logic                 enable;
  logic                 os_tick;
  logic                 rx_in;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;
`ifdef UART_PARITY_EN
  logic                 parity_err;

  modport master (output enable, os_tick, rx_in,
                  input  rx_data, rx_valid, frame_err, busy, parity_err);
  modport slave  (input  enable, os_tick, rx_in,
                  output rx_data, rx_valid, frame_err, busy, parity_err);
`else
  modport master (output enable, os_tick, rx_in,
                  input  rx_data, rx_valid, frame_err, busy);
  modport slave  (input  enable, os_tick, rx_in,
                  output rx_data, rx_valid, frame_err, busy);
`endif
endinterface

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - Oversampling 8N1 UART receiver driven by the prescaler's os_tick.
// UART_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_rx_os #(
  parameter int DATA_BITS = 8,
  parameter int OS_RATE   = 16
) (
  input logic          src_clk,
  input logic          rst,
  uart_rx_os_if.slave  rxIf
);
  localparam int TW = $clog2(OS_RATE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_MID  = TW'(OS_RATE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OS_RATE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state;
  logic [TW-1:0]        tickCnt;
  logic [BW-1:0]        bitCnt;
  logic [DATA_BITS-1:0] shiftReg;
  logic [DATA_BITS-1:0] rxData;
  logic                 rxValid;
  logic                 frameErr;
  logic                 busy;
  logic                 rxMeta;
  logic                 rxS;
`ifdef UART_PARITY_EN
  logic                 parityFault;
  logic                 parityErr;
  assign rxIf.parity_err = parityErr;
`endif

  assign rxIf.rx_data   = rxData;
  assign rxIf.rx_valid  = rxValid;
  assign rxIf.frame_err = frameErr;
  assign rxIf.busy      = busy;

  // Synchroniser resets to the idle-high line level so reset cannot fake a start bit.
  always_ff @(posedge src_clk) begin
    if (rst) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= rxIf.rx_in;
      rxS    <= rxMeta;
    end
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      state    <= IDLE;
      tickCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      rxData   <= '0;
      rxValid  <= 1'b0;
      frameErr <= 1'b0;
      busy     <= 1'b0;
`ifdef UART_PARITY_EN
      parityFault <= 1'b0;
      parityErr   <= 1'b0;
`endif
    end else begin
      rxValid  <= 1'b0;
      frameErr <= 1'b0;
`ifdef UART_PARITY_EN
      parityErr <= 1'b0;
`endif
      if (!rxIf.enable) begin
        state    <= IDLE;
        tickCnt  <= '0;
        bitCnt   <= '0;
        shiftReg <= '0;
        busy     <= 1'b0;
`ifdef UART_PARITY_EN
        parityFault <= 1'b0;
`endif
      end else if (rxIf.os_tick) begin
        case (state)
          IDLE: begin
            if (!rxS) begin
              state   <= START;
              tickCnt <= '0;
              busy    <= 1'b1;
`ifdef UART_PARITY_EN
              parityFault <= 1'b0;
`endif
            end
          end
          START: begin
            if (tickCnt == TICK_MID) begin
              tickCnt <= '0;
              bitCnt  <= '0;
              if (!rxS) begin
                state <= DATA;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tickCnt <= tickCnt + 1'b1;
            end
          end
          DATA: begin
            if (tickCnt == TICK_LAST) begin
              tickCnt  <= '0;
              shiftReg <= {rxS, shiftReg[DATA_BITS-1:1]};
              if (bitCnt == BIT_LAST) begin
`ifdef UART_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bitCnt <= bitCnt + 1'b1;
              end
            end else begin
              tickCnt <= tickCnt + 1'b1;
            end
          end
`ifdef UART_PARITY_EN
          PARITY: begin
            if (tickCnt == TICK_LAST) begin
              tickCnt     <= '0;
              parityFault <= ^{shiftReg, rxS};
              state       <= STOP;
            end else begin
              tickCnt <= tickCnt + 1'b1;
            end
          end
`endif
          STOP: begin
            // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
            if (tickCnt == TICK_LAST) begin
              tickCnt <= '0;
              state   <= IDLE;
              busy    <= 1'b0;
              if (!rxS) begin
                frameErr <= 1'b1;
`ifdef UART_PARITY_EN
              end else if (parityFault) begin
                parityErr <= 1'b1;
`endif
              end else begin
                rxValid <= 1'b1;
                rxData  <= shiftReg;
              end
            end else begin
              tickCnt <= tickCnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - Scoreboard bench for uart_rx_os: directed frames, glitch, enable abort.
// Build with UART_PARITY_EN to exercise the parity path as well.
module tb_uart_rx_os;
  localparam int BIT_CLKS = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails = 0;
  int   tickPhase = 0;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;
  exp_t expQ[$];

  uart_rx_os_if #(.DATA_BITS(8)) rxIf();

  uart_rx_os #(.DATA_BITS(8), .OS_RATE(16)) dut (
    .src_clk (clk),
    .rst     (rst),
    .rxIf    (rxIf)
  );

  always #5 clk = ~clk;

  initial begin
    rxIf.os_tick = 1'b0;
    forever begin
      @(negedge clk);
      rxIf.os_tick = (tickPhase == 3);
      tickPhase    = (tickPhase + 1) % 4;
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic pushExp(input int kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    expQ.push_back(e);
  endtask

  task automatic holdBit(input logic val);
    rxIf.rx_in = val;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] data, input logic parBit, input logic stopBit);
    holdBit(1'b0);
    for (int i = 0; i < 8; i++) holdBit(data[i]);
`ifdef UART_PARITY_EN
    holdBit(parBit);
`endif
    holdBit(stopBit);
  endtask

  // Monitor: kinds are 0 = rx_valid, 1 = frame_err, 2 = parity_err.
  int   monKind;
  int   monCount;
  exp_t monExp;
  always @(negedge clk) begin
    if (!rst) begin
      monCount = 0;
      monKind  = -1;
      if (rxIf.rx_valid)  begin monCount++; monKind = 0; end
      if (rxIf.frame_err) begin monCount++; monKind = 1; end
`ifdef UART_PARITY_EN
      if (rxIf.parity_err) begin monCount++; monKind = 2; end
`endif
      if (monCount > 0) begin
        check("strobe_exclusive", monCount, 1);
        if (expQ.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_strobe: got kind %0d data 0x%0h, expected no strobe", monKind, rxIf.rx_data);
        end else begin
          monExp = expQ.pop_front();
          check("strobe_kind", monKind, monExp.kind);
          check("rx_data", int'(rxIf.rx_data), int'(monExp.data));
        end
      end
    end
  end

  initial begin
    rxIf.enable = 1'b1;
    rxIf.rx_in  = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_rx_data", int'(rxIf.rx_data), 0);
    check("reset_rx_valid", int'(rxIf.rx_valid), 0);
    check("reset_frame_err", int'(rxIf.frame_err), 0);
    check("reset_busy", int'(rxIf.busy), 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // 0xA5 good frame
    pushExp(0, 8'hA5);
    sendFrame(8'hA5, 1'b0, 1'b1);
    check("busy_after_a5", int'(rxIf.busy), 0);
    repeat (40) @(negedge clk);

    // 0x3C with low stop bit: frame error, data stays 0xA5
    pushExp(1, 8'hA5);
    sendFrame(8'h3C, 1'b0, 1'b0);
    rxIf.rx_in = 1'b1;
    repeat (100) @(negedge clk);

    // start glitch of 3 ticks
    rxIf.rx_in = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_busy_high", int'(rxIf.busy), 1);
    rxIf.rx_in = 1'b1;
    for (int i = 0; i < 40 && rxIf.busy; i++) @(negedge clk);
    check("glitch_busy_low", int'(rxIf.busy), 0);
    repeat (100) @(negedge clk);

    // back-to-back 0x00 then 0xFF
    pushExp(0, 8'h00);
    sendFrame(8'h00, 1'b0, 1'b1);
    pushExp(0, 8'hFF);
    sendFrame(8'hFF, 1'b0, 1'b1);
    check("busy_after_ff", int'(rxIf.busy), 0);
    repeat (40) @(negedge clk);

    // enable dropped after 4 data bits of 0x5A, then 0x81
    holdBit(1'b0);
    holdBit(1'b0);
    holdBit(1'b1);
    holdBit(1'b0);
    holdBit(1'b1);
    rxIf.enable = 1'b0;
    rxIf.rx_in  = 1'b1;
    repeat (100) @(negedge clk);
    check("disabled_busy", int'(rxIf.busy), 0);
    check("disabled_rx_data", int'(rxIf.rx_data), 8'hFF);
    rxIf.enable = 1'b1;
    repeat (64) @(negedge clk);
    pushExp(0, 8'h81);
    sendFrame(8'h81, 1'b0, 1'b1);
    repeat (40) @(negedge clk);

`ifdef UART_PARITY_EN
    // 0x07 has three ones; correct even parity bit is 1, send 0
    pushExp(2, 8'h81);
    sendFrame(8'h07, 1'b0, 1'b1);
    repeat (40) @(negedge clk);
    pushExp(0, 8'h07);
    sendFrame(8'h07, 1'b1, 1'b1);
    repeat (40) @(negedge clk);
`endif

    repeat (200) @(negedge clk);
    check("scoreboard_drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
